// File: rtl/apb_decoder_mux.sv
// APB3 one-master / N-slave interconnect: address decode into equal-span
// windows, response mux, decode-miss error and a wait-state watchdog.
// Optional build macro APB_DECODER_STATS_EN adds error/timeout statistics
// outputs (err_count, timeout_count, last_err_addr).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | no transfer in flight; waits for a setup phase
//  S_ACCESS | access phase; waits for slave ready, miss or watchdog
//  S_ABORT  | one cycle with all slave selects forced low after timeout
module apb_decoder_mux #(
  parameter int unsigned          N_SLAVES        = 4,
  parameter int unsigned          ADDR_W          = 32,
  parameter int unsigned          DATA_W          = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR       = 32'h8c000000,
  parameter logic [ADDR_W-1:0]    SLAVE_SPAN      = 32'h10,
  parameter int unsigned          MAX_WAIT_STATES = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [N_SLAVES-1:0]          s_PSEL,
  output logic                         s_PENABLE,
  output logic                         s_PWRITE,
  output logic [ADDR_W-1:0]            s_PADDR,
  output logic [DATA_W-1:0]            s_PWDATA,
  input  logic [N_SLAVES*DATA_W-1:0]   s_PRDATA,
  input  logic [N_SLAVES-1:0]          s_PREADY,
  input  logic [N_SLAVES-1:0]          s_PSLVERR,
  output logic                         timeout
`ifdef APB_DECODER_STATS_EN
  ,
  output logic [15:0]                  err_count,
  output logic [15:0]                  timeout_count,
  output logic [ADDR_W-1:0]            last_err_addr
`endif
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (MAX_WAIT_STATES > 0) ? $clog2(MAX_WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT_STATES);

  // Configuration sanity: span must be a power of two, base aligned to it,
  // and the whole map must fit below 2^ADDR_W without wrapping.
  if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_nslaves
    $error("apb_decoder_mux: N_SLAVES must be 1..16");
  end
  if (SLAVE_SPAN == '0 || (SLAVE_SPAN & (SLAVE_SPAN - 1'b1)) != '0) begin : g_bad_span
    $error("apb_decoder_mux: SLAVE_SPAN must be a power of two");
  end
  if ((BASE_ADDR & (SLAVE_SPAN - 1'b1)) != '0) begin : g_bad_align
    $error("apb_decoder_mux: BASE_ADDR not aligned to SLAVE_SPAN");
  end
  if (ADDR_W < 63) begin : g_wrap_chk
    localparam longint unsigned MAP_END =
      64'(BASE_ADDR) + 64'(N_SLAVES) * 64'(SLAVE_SPAN);
    if (MAP_END > (64'd1 << ADDR_W)) begin : g_bad_wrap
      $error("apb_decoder_mux: slave windows wrap past the top of the address space");
    end
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ABORT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
  logic                miss_q, miss_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic [N_SLAVES-1:0] hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                miss;
  logic                setup;
  logic                kill;
  logic                rsp_ready;
  logic                rsp_err;
  logic [DATA_W-1:0]   rsp_data;
  logic                to_pulse;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  // Window decode; widened by one bit so the upper bound never wraps.
  always_comb begin
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] addr_x;
    hit     = '0;
    dec_idx = '0;
    addr_x  = {1'b0, PADDR};
    for (int i = 0; i < N_SLAVES; i++) begin
      lo = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(i) * {1'b0, SLAVE_SPAN};
      if (addr_x >= lo && addr_x < lo + {1'b0, SLAVE_SPAN}) begin
        hit[i]  = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
  end

  assign miss  = PSEL & ~(|hit);
  assign setup = PSEL & ~PENABLE;

  // Select the latched slave's ready/error/data.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_idx_q == IDX_W'(i)) begin
        sel_ready = s_PREADY[i];
        sel_err   = s_PSLVERR[i];
        sel_rdata = s_PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and response logic.
  always_comb begin
    state_d    = state_q;
    sel_idx_d  = sel_idx_q;
    miss_d     = miss_q;
    wait_cnt_d = wait_cnt_q;
    kill       = 1'b0;
    rsp_ready  = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    to_pulse   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d    = S_ACCESS;
          sel_idx_d  = dec_idx;
          miss_d     = miss;
          wait_cnt_d = '0;
        end
      end
      S_ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it silently.
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (miss_q) begin
          rsp_ready = 1'b1;
          rsp_err   = 1'b1;
          state_d   = S_IDLE;
        end else if (sel_ready) begin
          rsp_ready = 1'b1;
          rsp_err   = sel_err;
          rsp_data  = sel_rdata;
          state_d   = S_IDLE;
        end else if (wait_cnt_q == WAIT_MAX) begin
          rsp_ready = 1'b1;
          rsp_err   = 1'b1;
          kill      = 1'b1;
          to_pulse  = 1'b1;
          state_d   = S_ABORT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ABORT: begin
        kill = 1'b1;
        if (setup) begin
          state_d    = S_ACCESS;
          sel_idx_d  = dec_idx;
          miss_d     = miss;
          wait_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_idx_q  <= '0;
      miss_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
      miss_q     <= miss_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign s_PSEL    = (PSEL && !kill && !rst) ? hit : '0;
  assign s_PENABLE = PENABLE;
  assign s_PWRITE  = PWRITE;
  assign s_PADDR   = PADDR;
  assign s_PWDATA  = PWDATA;

  assign PREADY  = rsp_ready & ~rst;
  assign PSLVERR = rsp_err & ~rst;
  assign PRDATA  = rst ? '0 : rsp_data;
  assign timeout = to_pulse & ~rst;

`ifdef APB_DECODER_STATS_EN
  logic err_evt;

  // Only decode misses and watchdog aborts count; slave-reported errors do not.
  assign err_evt = rsp_ready & rsp_err & (miss_q | to_pulse);

  // Saturating error statistics, captured at the end of the error cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count     <= '0;
      timeout_count <= '0;
      last_err_addr <= '0;
    end else if (err_evt) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (to_pulse && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      last_err_addr <= PADDR;
    end
  end
`endif

endmodule
